image_capture_multi: RTL
========================

IMAGE_CAPTURE_MULTI -- requirements
Module: image_capture_multi

Interface
REQ-001 SHALL have parameter X_W, default 10, pixel x-coordinate width.
REQ-002 SHALL have parameter Y_W, default 9, pixel y-coordinate width.
REQ-003 SHALL have parameter MAX_W, default 640, max pixels per line.
REQ-004 SHALL have parameter MAX_H, default 480, max lines per frame.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  system clock, sole clock
- rst  in  1  synchronous active-low reset
- en  in  1  capture enable, sampled at frame start
- mode  in  2  00 RGB444, 01 RGB565, 10 RAW8, 11 treated as RGB565
- vsync  in  1  camera frame sync, asynchronous
- href  in  1  camera line valid, asynchronous
- pclk  in  1  camera pixel clock, sampled as data, never used as clock
- data  in  8  camera byte bus
- pixel_data  out  16  assembled pixel
- pixel_valid  out  1  one-clk pixel strobe
- pixel_x  out  X_W  column of current pixel_data
- pixel_y  out  Y_W  row of current pixel_data
- line_done  out  1  one-clk pulse per line end
- frame_done  out  1  one-clk pulse per captured frame end
- frame_count  out  16  captured frames, wraps at 16'hFFFF->0
- line_err  out  1  sticky per frame: odd byte count or line/row overflow
- busy  out  1  high while in CAPTURE

Function
REQ-006 SHALL pass vsync, href and pclk through two-flop synchronisers; data SHALL be delayed two clk so it stays aligned with synchronised pclk.
REQ-007 SHALL detect a pclk rising edge when synchronised pclk=1 and its previous value=0; every byte action SHALL occur only on a detected edge with synchronised href=1.
REQ-008 SHALL support pclk high and low phases of >=2 clk each; faster pclk is out of scope.
REQ-009 SHALL implement states IDLE, WAIT_SOF, CAPTURE, SKIP.
REQ-010 IDLE: synchronised vsync=1 -> WAIT_SOF.
REQ-011 WAIT_SOF: vsync falling edge -> CAPTURE if en=1, else SKIP; mode SHALL be latched at this edge and held for the frame.
REQ-012 CAPTURE: vsync rising edge -> frame_done=1 one clk, frame_count+1, -> WAIT_SOF.
REQ-013 SKIP: vsync rising edge -> WAIT_SOF, no frame_done, no count change.
REQ-014 RGB444: byte0 then byte1, pixel_data={4'h0,byte0[3:0],byte1}.
REQ-015 RGB565: pixel_data={byte0,byte1}.
REQ-016 RAW8: every byte is a pixel, pixel_data={8'h00,byte}.
REQ-017 pixel_valid SHALL pulse exactly 3 clk after the first clk edge that samples raw pclk=1 for the completing byte.
REQ-018 pixel_x SHALL be 0 for the first pixel of a line and increment per pixel; pixel_y SHALL be 0 for the first line of a frame.
REQ-019 href falling edge in CAPTURE: line_done=1 one clk, byte phase->0, x->0, y+1.
REQ-020 href falling with byte phase=1 (2-byte modes): half pixel discarded, line_err=1.
REQ-021 Pixels with x>=MAX_W or lines with y>=MAX_H SHALL be dropped (no pixel_valid), line_err=1; counters SHALL not wrap.
REQ-022 line_err SHALL clear at each CAPTURE entry.
REQ-023 href falling and vsync rising detected on the same clk: line_done and frame_done SHALL both pulse on that clk.
REQ-024 busy SHALL be 1 exactly while state=CAPTURE.

Reset
REQ-025 rst=0 at a clk edge SHALL force state IDLE, all outputs 0, frame_count 0, synchronisers 0, byte phase 0.
REQ-026 Reset mid-frame SHALL abandon the frame; capture SHALL resume only after a complete vsync high->low sequence.

Verification
REQ-027 clk 100 MHz, pclk 25 MHz, mode=00, en=1, one line bytes F0,0F,AA,55 -> pixel_data 000F (x=0), 0A55 (x=1), line_done once, frame_done once, frame_count=1.
REQ-028 mode=01, bytes 12,34 -> pixel_data 1234; mode=10, bytes 12,34 -> 0012 then 0034, x=0,1.
REQ-029 en=0 at vsync fall -> no pixel_valid, no frame_done, frame_count unchanged, busy=0.
REQ-030 Line of 3 bytes in mode=01 -> one pixel, line_err=1; 642 pixels with MAX_W=640 -> 640 pixel_valid, line_err=1.
REQ-031 rst=0 after 2 pixels mid-line -> all outputs 0 next clk; released mid-frame -> no pixel_valid until next vsync high->low.
REQ-032 href fall and vsync rise on same sampled clk -> line_done and frame_done high on the same clk.

Source files
------------

// File: rtl/image_capture_multi.sv
// Camera capture front end: synchronises a DVP-style camera bus into the clk
// domain and assembles RGB444 / RGB565 / RAW8 pixels with x/y coordinates.
module image_capture_multi #(
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  parameter int MAX_W = 640,
  parameter int MAX_H = 480
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [1:0]     mode,
  input  logic           vsync,
  input  logic           href,
  input  logic           pclk,
  input  logic [7:0]     data,
  output logic [15:0]    pixel_data,
  output logic           pixel_valid,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           line_done,
  output logic           frame_done,
  output logic [15:0]    frame_count,
  output logic           line_err,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    SKIP     = 2'd3
  } state_t;

  localparam logic [1:0] MODE_RGB444 = 2'b00;
  localparam logic [1:0] MODE_RAW8   = 2'b10;

  localparam logic [X_W:0] X_LIMIT = (X_W + 1)'(MAX_W);
  localparam logic [Y_W:0] Y_LIMIT = (Y_W + 1)'(MAX_H);

  state_t state, state_next;

  // Bit 0/1 form the two-flop synchroniser, bit 2 is the previous value for edge detection.
  logic [2:0] vs_sh, hr_sh, pc_sh;
  logic [7:0] data_d1, data_d2;

  logic       pclk_rise_q;
  logic       href_q;
  logic       href_fall_q;
  logic       vs_q;
  logic       vs_rise_q;
  logic       vs_fall_q;
  logic [7:0] byte_q;

  logic [1:0]   mode_q;
  logic         phase;
  logic [7:0]   byte0;
  logic [X_W:0] x_cnt;
  logic [Y_W:0] y_cnt;

  logic        sof;
  logic        eof_cap;
  logic        byte_ev;
  logic        line_end;
  logic        completes;
  logic        in_range;
  logic [15:0] assembled;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vs_sh   <= '0;
      hr_sh   <= '0;
      pc_sh   <= '0;
      data_d1 <= '0;
      data_d2 <= '0;
    end else begin
      vs_sh   <= {vs_sh[1:0], vsync};
      hr_sh   <= {hr_sh[1:0], href};
      pc_sh   <= {pc_sh[1:0], pclk};
      data_d1 <= data;
      data_d2 <= data_d1;
    end
  end

  // Edge events are registered once so every action lands three clk after raw pclk is first seen high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pclk_rise_q <= 1'b0;
      href_q      <= 1'b0;
      href_fall_q <= 1'b0;
      vs_q        <= 1'b0;
      vs_rise_q   <= 1'b0;
      vs_fall_q   <= 1'b0;
      byte_q      <= '0;
    end else begin
      pclk_rise_q <= pc_sh[1] & ~pc_sh[2];
      href_q      <= hr_sh[1];
      href_fall_q <= ~hr_sh[1] & hr_sh[2];
      vs_q        <= vs_sh[1];
      vs_rise_q   <= vs_sh[1] & ~vs_sh[2];
      vs_fall_q   <= ~vs_sh[1] & vs_sh[2];
      byte_q      <= data_d2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    sof        = 1'b0;
    eof_cap    = 1'b0;
    byte_ev    = 1'b0;
    line_end   = 1'b0;
    unique case (state)
      IDLE: begin
        if (vs_q) state_next = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (vs_fall_q) begin
          sof        = 1'b1;
          state_next = en ? CAPTURE : SKIP;
        end
      end
      CAPTURE: begin
        byte_ev  = pclk_rise_q & href_q;
        line_end = href_fall_q;
        if (vs_rise_q) begin
          eof_cap    = 1'b1;
          state_next = WAIT_SOF;
        end
      end
      SKIP: begin
        if (vs_rise_q) state_next = WAIT_SOF;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    completes = (mode_q == MODE_RAW8) | phase;
    in_range  = (x_cnt < X_LIMIT) && (y_cnt < Y_LIMIT);
    if (mode_q == MODE_RAW8) begin
      assembled = {8'h00, byte_q};
    end else if (mode_q == MODE_RGB444) begin
      assembled = {4'h0, byte0[3:0], byte_q};
    end else begin
      assembled = {byte0, byte_q};
    end
  end

  assign busy = (state == CAPTURE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q      <= '0;
      phase       <= 1'b0;
      byte0       <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_done   <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      line_err    <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      line_done   <= 1'b0;
      frame_done  <= 1'b0;

      if (sof) begin
        mode_q <= mode;
        phase  <= 1'b0;
        x_cnt  <= '0;
        y_cnt  <= '0;
        if (en) line_err <= 1'b0;
      end

      if (byte_ev) begin
        if (completes) begin
          phase <= 1'b0;
          // Out-of-range pixels are dropped and x saturates instead of wrapping.
          if (in_range) begin
            pixel_valid <= 1'b1;
            pixel_data  <= assembled;
            pixel_x     <= x_cnt[X_W-1:0];
            pixel_y     <= y_cnt[Y_W-1:0];
            x_cnt       <= x_cnt + (X_W + 1)'(1);
          end else begin
            line_err <= 1'b1;
          end
        end else begin
          byte0 <= byte_q;
          phase <= 1'b1;
        end
      end

      if (line_end) begin
        line_done <= 1'b1;
        phase     <= 1'b0;
        x_cnt     <= '0;
        if (y_cnt < Y_LIMIT) y_cnt <= y_cnt + (Y_W + 1)'(1);
        if (phase) line_err <= 1'b1;
      end

      if (eof_cap) begin
        frame_done  <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule
